// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of one synchronous single-ported memory.
// Grant is combinational; read data returns the cycle after the granted address.
module mem_arbiter #(
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 16,
    parameter int RR      = 0,
    parameter int MAXWAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [AWIDTH-1:0] addr0_i,
    input  logic [AWIDTH-1:0] addr1_i,
    input  logic [DWIDTH-1:0] wdata0_i,
    input  logic [DWIDTH-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic [AWIDTH-1:0] mem_raddr_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [AWIDTH-1:0] mem_waddr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o
);
    localparam int          NPORTS    = 2;
    localparam logic [3:0]  MAXWAIT_W = 4'(MAXWAIT);

    typedef struct packed {
        logic              req;
        logic              we;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] wdata;
    } port_req_t;

    port_req_t [NPORTS-1:0] preq;
    logic [NPORTS-1:0]      gnt;
    logic                   g0, g1, pick1;
    logic                   last_q, last_d;
    logic [3:0]             wait1_q, wait1_d;
    logic [1:0]             rtag_q, rtag_d;
    logic [AWIDTH-1:0]      mem_addr;
    logic [DWIDTH-1:0]      mem_wdata;
    logic                   mem_wr, mem_rd;

    assign preq[0] = {req0_i, we0_i, addr0_i, wdata0_i};
    assign preq[1] = {req1_i, we1_i, addr1_i, wdata1_i};

    // pick1 only matters when both ports request at once.
    if (RR != 0) begin : g_rr
        assign pick1 = ~last_q;
    end else begin : g_fp
        assign pick1 = (wait1_q >= MAXWAIT_W);
    end

    // Gating with rst_n keeps every grant-derived output low during reset.
    always_comb begin
        g1 = 1'b0;
        g0 = 1'b0;
        if (rst_n) begin
            g1 = preq[1].req & (~preq[0].req | pick1);
            g0 = preq[0].req & ~g1;
        end
    end

    assign gnt = {g1, g0};

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt[p]) begin
                mem_addr  = preq[p].addr;
                mem_wdata = preq[p].wdata;
                mem_wr    = preq[p].we;
                mem_rd    = ~preq[p].we;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (g1)
            last_d = 1'b1;
        else if (g0)
            last_d = 1'b0;

        wait1_d = '0;
        if (req1_i && !g1)
            wait1_d = (wait1_q == 4'hF) ? wait1_q : wait1_q + 4'd1;

        rtag_d = mem_rd ? {1'b1, g1} : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            wait1_q <= '0;
            rtag_q  <= '0;
        end else begin
            last_q  <= last_d;
            wait1_q <= wait1_d;
            rtag_q  <= rtag_d;
        end
    end

    assign gnt0_o      = g0;
    assign gnt1_o      = g1;
    assign mem_raddr_o = mem_addr;
    assign mem_waddr_o = mem_addr;
    assign mem_wdata_o = mem_wdata;
    assign mem_wr_o    = mem_wr;
    assign mem_rd_o    = mem_rd;
    assign rvalid0_o   = rtag_q[1] & ~rtag_q[0];
    assign rvalid1_o   = rtag_q[1] &  rtag_q[0];
    assign rdata_o     = mem_rdata_i;

    a_onehot_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0_o && gnt1_o));
    a_gnt0_req:   assert property (@(posedge clk) disable iff (!rst_n) gnt0_o |-> req0_i);
    a_gnt1_req:   assert property (@(posedge clk) disable iff (!rst_n) gnt1_o |-> req1_i);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority instance and a round-robin instance share stimulus;
// directed scenarios plus a randomized run checked against an abstract arbitration model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MAXWAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          gnt0, gnt1, rv0, rv1, mwr, mrd;
    logic [AW-1:0] mraddr, mwaddr;
    logic [DW-1:0] rdata, mwdata, mrdata;

    logic          gnt0_r, gnt1_r, rv0_r, rv1_r, mwr_r, mrd_r;
    logic [AW-1:0] mraddr_r, mwaddr_r;
    logic [DW-1:0] rdata_r, mwdata_r, mrdata_r;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .RR(0), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rv0), .rvalid1_o(rv1),
        .rdata_o(rdata), .mem_raddr_o(mraddr), .mem_rdata_i(mrdata),
        .mem_waddr_o(mwaddr), .mem_wdata_o(mwdata), .mem_wr_o(mwr), .mem_rd_o(mrd)
    );

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .RR(1), .MAXWAIT(MAXWAIT)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0_r), .gnt1_o(gnt1_r), .rvalid0_o(rv0_r), .rvalid1_o(rv1_r),
        .rdata_o(rdata_r), .mem_raddr_o(mraddr_r), .mem_rdata_i(mrdata_r),
        .mem_waddr_o(mwaddr_r), .mem_wdata_o(mwdata_r), .mem_wr_o(mwr_r), .mem_rd_o(mrd_r)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h3C3C);
    endfunction

    // Memory stores value XOR init_val so the zero-initialised 2-state array starts at init_val.
    bit [DW-1:0] env_delta [0:65535];
    always @(posedge clk) begin
        if (mwr) env_delta[mwaddr] <= mwdata ^ init_val(mwaddr);
        mrdata   <= env_delta[mraddr] ^ init_val(mraddr);
        mrdata_r <= mraddr_r ^ 16'h1111;
    end

    task automatic drive(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 16'h0010, 0, 1, 1, 16'h0020, 16'h1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, mwr, mrd, rv0, rv1, gnt0_r, gnt1_r} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000000", {gnt0, gnt1, mwr, mrd, rv0, rv1, gnt0_r, gnt1_r});
        end
        vectors++;
        if ({mraddr, mwaddr, mwdata} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_buses: got %h want 0", {mraddr, mwaddr, mwdata});
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({gnt0, gnt1, mrd} !== 3'b101) begin
            miscompares++;
            $display("FAIL reset_first_gnt: got %b want 101", {gnt0, gnt1, mrd});
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({rv0, rv1} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_first_rvalid: got %b want 10", {rv0, rv1});
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        drive(1, 0, 16'h0040, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, mrd, mwr, mraddr} !== {4'b1010, 16'h0040}) begin
            miscompares++;
            $display("FAIL single_read_issue: got %b/%h want 1010/0040", {gnt0, gnt1, mrd, mwr}, mraddr);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({rv0, rv1, rdata} !== {2'b10, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL single_read_return: got %b/%h want 10/beef", {rv0, rv1}, rdata);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        drive(0, 0, 0, 0, 1, 1, 16'h1234, 16'hA5A5);
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, mwr, mrd, mwaddr, mwdata} !== {4'b0110, 16'h1234, 16'hA5A5}) begin
            miscompares++;
            $display("FAIL write_issue: got %b/%h/%h want 0110/1234/a5a5", {gnt0, gnt1, mwr, mrd}, mwaddr, mwdata);
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 16'h1234, 0);
        @(negedge clk);
        vectors++;
        if ({gnt1, mrd, mwr, mraddr, rv0, rv1} !== {3'b110, 16'h1234, 2'b00}) begin
            miscompares++;
            $display("FAIL readback_issue: got %b/%h/%b want 110/1234/00", {gnt1, mrd, mwr}, mraddr, {rv0, rv1});
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({rv0, rv1, rdata} !== {2'b01, 16'hA5A5}) begin
            miscompares++;
            $display("FAIL readback_return: got %b/%h want 01/a5a5", {rv0, rv1}, rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] seq_a [3];
        logic [DW-1:0] seq_d [3];
        seq_a[0] = 16'h0040; seq_d[0] = 16'hBEEF;
        seq_a[1] = 16'h1234; seq_d[1] = 16'hA5A5;
        seq_a[2] = 16'h0041; seq_d[2] = 16'h3C7D;
        for (int c = 0; c < 4; c++) begin
            if (c == 3)      drive(0, 0, 0, 0, 0, 0, 0, 0);
            else if (c == 1) drive(0, 0, 0, 0, 1, 0, seq_a[c], 0);
            else             drive(1, 0, seq_a[c], 0, 0, 0, 0, 0);
            @(negedge clk);
            if (c < 3) begin
                vectors++;
                if ({gnt0, gnt1, mrd} !== {c != 1, c == 1, 1'b1}) begin
                    miscompares++;
                    $display("FAIL b2b_gnt[%0d]: got %b want %b", c, {gnt0, gnt1, mrd}, {c != 1, c == 1, 1'b1});
                end
            end
            if (c > 0) begin
                vectors++;
                if ({rv0, rv1, rdata} !== {c != 2, c == 2, seq_d[c-1]}) begin
                    miscompares++;
                    $display("FAIL b2b_rvalid[%0d]: got %b/%h want %b/%h", c, {rv0, rv1}, rdata, {c != 2, c == 2}, seq_d[c-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a [2];
        logic [AW-1:0] preva;
        int prevp, expp;
        a[0] = 16'h0200;
        a[1] = 16'h0300;
        drive(0, 0, 0, 0, 1, 0, a[1], 0);
        @(negedge clk);
        vectors++;
        if ({gnt0_r, gnt1_r} !== 2'b01) begin
            miscompares++;
            $display("FAIL rr_prime: got %b want 01", {gnt0_r, gnt1_r});
        end
        prevp = 1; preva = a[1]; a[1] = 16'($urandom);
        expp = 0;
        next_cycle();
        for (int c = 0; c < 7; c++) begin
            if (c < 6) drive(1, 0, a[0], 0, 1, 0, a[1], 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (c < 6) begin
                vectors++;
                if ({gnt0_r, gnt1_r} !== {expp == 0, expp == 1}) begin
                    miscompares++;
                    $display("FAIL rr_gnt[%0d]: got %b want %b", c, {gnt0_r, gnt1_r}, {expp == 0, expp == 1});
                end
            end
            vectors++;
            if ({rv0_r, rv1_r, rdata_r} !== {prevp == 0, prevp == 1, preva ^ 16'h1111}) begin
                miscompares++;
                $display("FAIL rr_rvalid[%0d]: got %b/%h want %b/%h", c, {rv0_r, rv1_r}, rdata_r,
                         {prevp == 0, prevp == 1}, preva ^ 16'h1111);
            end
            prevp = expp; preva = a[expp];
            a[expp] = 16'($urandom);
            expp = 1 - expp;
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        int w = 0;
        int prevp = -1;
        logic e1;
        for (int c = 0; c < 11; c++) begin
            drive(1, 0, 16'(16'h0400 + c), 0, 1, 0, 16'h0500, 0);
            @(negedge clk);
            e1 = (w >= MAXWAIT);
            vectors++;
            if ({gnt0, gnt1} !== {!e1, e1}) begin
                miscompares++;
                $display("FAIL starve_gnt[%0d]: got %b want %b", c, {gnt0, gnt1}, {!e1, e1});
            end
            vectors++;
            if ({rv0, rv1} !== {prevp == 0, prevp == 1}) begin
                miscompares++;
                $display("FAIL starve_rvalid[%0d]: got %b want %b", c, {rv0, rv1}, {prevp == 0, prevp == 1});
            end
            w = e1 ? 0 : ((w < 15) ? w + 1 : 15);
            prevp = e1 ? 1 : 0;
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_withdraw();
        logic r1pat [6];
        r1pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        // A withdrawal must reset the wait count, so port 1 never reaches MAXWAIT here.
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, 16'h0700, 0, r1pat[c], 0, 16'h0710, 0);
            @(negedge clk);
            vectors++;
            if ({gnt0, gnt1} !== 2'b10) begin
                miscompares++;
                $display("FAIL withdraw_gnt[%0d]: got %b want 10", c, {gnt0, gnt1});
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 1, 0, 16'h1234, 0);
        next_cycle();
        drive(1, 1, 16'h0600, 16'h5A5A, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, mwr, mrd, mwaddr, mwdata, rv0, rv1, rdata}
                !== {4'b1010, 16'h0600, 16'h5A5A, 2'b01, 16'hA5A5}) begin
            miscompares++;
            $display("FAIL simul_write_rvalid: got %b/%h/%h/%b/%h want 1010/0600/5a5a/01/a5a5",
                     {gnt0, gnt1, mwr, mrd}, mwaddr, mwdata, {rv0, rv1}, rdata);
        end
        next_cycle();
        drive(1, 0, 16'h0600, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({rv0, rv1, gnt0} !== 3'b001) begin
            miscompares++;
            $display("FAIL write_no_rvalid: got %b want 001", {rv0, rv1, gnt0});
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({rv0, rdata} !== {1'b1, 16'h5A5A}) begin
            miscompares++;
            $display("FAIL write_commit: got %b/%h want 1/5a5a", rv0, rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 16'h0040, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_pre_gnt: got %b want 1", gnt0);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({gnt0, mrd, mraddr} !== 18'h0) begin
            miscompares++;
            $display("FAIL mid_reset_gated: got %b/%h want 00/0000", {gnt0, mrd}, mraddr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({rv0, rv1, gnt0, gnt1, rv0_r, rv1_r} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_rvalid: got %b want 000000", {rv0, rv1, gnt0, gnt1, rv0_r, rv1_r});
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [DW-1:0] mdl_mem [int];
        logic          pr [2];
        logic          pw [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        logic          gp [2];
        logic          e0, e1, ewr, erd;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, exp_rd;
        int            mw, mrv, p;
        mdl_mem[32'h1234] = 16'hA5A5;
        mdl_mem[32'h0600] = 16'h5A5A;
        mw = 0; mrv = -1; exp_rd = '0;
        for (int q = 0; q < 2; q++) begin
            pr[q] = 0; pw[q] = 0; pa[q] = 0; pd[q] = 0; gp[q] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pr[q] || gp[q]) begin
                    pr[q] = ($urandom_range(0, 9) < 6);
                    pw[q] = $urandom_range(0, 1) == 1;
                    case ($urandom_range(0, 3))
                        0: pa[q] = 16'h0040;
                        1: pa[q] = 16'h1234;
                        2: pa[q] = 16'h0600;
                        default: pa[q] = 16'(16'h0700 + $urandom_range(0, 7));
                    endcase
                    pd[q] = 16'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    pr[q] = 0;
                end
            end
            drive(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
            @(negedge clk);
            e1 = pr[1] && (!pr[0] || mw >= MAXWAIT);
            e0 = pr[0] && !e1;
            p = e1 ? 1 : 0;
            ewr = (e0 || e1) && pw[p];
            erd = (e0 || e1) && !pw[p];
            ea  = (e0 || e1) ? pa[p] : '0;
            ewd = (e0 || e1) ? pd[p] : '0;
            vectors++;
            if ({gnt0, gnt1, mwr, mrd, mraddr, mwaddr, mwdata} !== {e0, e1, ewr, erd, ea, ea, ewd}) begin
                miscompares++;
                $display("FAIL rand_issue[%0d]: got %b/%h/%h/%h want %b/%h/%h/%h", c,
                         {gnt0, gnt1, mwr, mrd}, mraddr, mwaddr, mwdata, {e0, e1, ewr, erd}, ea, ea, ewd);
            end
            vectors++;
            if ({rv0, rv1} !== {mrv == 0, mrv == 1} || (mrv >= 0 && rdata !== exp_rd)) begin
                miscompares++;
                $display("FAIL rand_return[%0d]: got %b/%h want %b/%h", c, {rv0, rv1}, rdata,
                         {mrv == 0, mrv == 1}, exp_rd);
            end
            if (erd) begin
                mrv = p;
                exp_rd = mdl_mem.exists(int'(ea)) ? mdl_mem[int'(ea)] : init_val(ea);
            end else begin
                mrv = -1;
            end
            if (ewr) mdl_mem[int'(ea)] = ewd;
            mw = (pr[1] && !e1) ? ((mw < 15) ? mw + 1 : 15) : 0;
            gp[0] = e0;
            gp[1] = e1;
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_round_robin();
        test_starvation();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
